// File: rtl/run_sequencer_pkg.sv
// Purpose: shared state encoding and default sizing for the run sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package run_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_GAP    = 3'd2,
        S_FINISH = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int DEF_ITER_W  = 16;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: count updates one cycle after i_inc; clear has priority over inc.
// Backpressure: none; i_inc is ignored once saturated.
// Ports: i_clk, i_rst (sync, active-high), i_clr, i_inc -> o_count, o_sat.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_sat
);

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_sat   = &r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Purpose: accepts a batch from the host (4-phase req/ack) and starts the datapath once per iteration.
// Latency: dp_start rises 1 cycle after acceptance; host_ack rises 1 cycle after the final dp_done.
// Backpressure: waits on dp_done each iteration; a per-iteration watchdog aborts to FAULT.
// Ports: i_clock, i_reset (sync, active-high); host side i_host_req, i_host_iterations,
//        o_host_ack, o_busy, o_timeout, o_total_cycles; datapath side o_dp_start, i_dp_done.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int ITER_W  = DEF_ITER_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_host_req,
    input  logic [ITER_W-1:0] i_host_iterations,
    output logic              o_host_ack,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_total_cycles,
    output logic              o_dp_start,
    input  logic              i_dp_done
);

    // Watchdog only needs to reach TIMEOUT-1.
    localparam int                WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [ITER_W-1:0] r_remaining;
    logic              r_timeout;

    logic              w_accept;
    logic              w_tot_inc;
    logic              w_wd_clr;
    logic              w_wd_inc;
    logic [WD_W-1:0]   w_wd_count;
    logic              w_wd_sat;
    logic              w_wd_expired;
    logic              w_tot_sat;

    assign w_accept  = (r_state == S_IDLE) && i_host_req;
    assign w_tot_inc = (r_state == S_RUN) || (r_state == S_GAP);
    assign w_wd_inc  = (r_state == S_RUN);
    // A completed iteration restarts the watchdog for the next one.
    assign w_wd_clr  = w_accept || ((r_state == S_RUN) && i_dp_done);
    // Saturation can only coincide with or follow WD_LAST; it is a backstop.
    assign w_wd_expired = (w_wd_count == WD_LAST) || w_wd_sat;

    sat_counter #(.W(CNT_W)) u_total (
        .i_clk   (i_clock),
        .i_rst   (i_reset),
        .i_clr   (w_accept),
        .i_inc   (w_tot_inc),
        .o_count (o_total_cycles),
        .o_sat   (w_tot_sat)
    );

    sat_counter #(.W(WD_W)) u_watchdog (
        .i_clk   (i_clock),
        .i_rst   (i_reset),
        .i_clr   (w_wd_clr),
        .i_inc   (w_wd_inc),
        .o_count (w_wd_count),
        .o_sat   (w_wd_sat)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_host_req) begin
                        r_remaining <= i_host_iterations;
                        r_timeout   <= 1'b0;
                        r_state     <= (i_host_iterations == '0) ? S_FINISH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_dp_done) begin
                        if (r_remaining == ITER_W'(1)) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                            r_state     <= S_GAP;
                        end
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_FAULT;
                    end
                end
                // One low cycle so every iteration sees a fresh start edge.
                S_GAP: r_state <= S_RUN;
                S_FINISH, S_FAULT: begin
                    if (!i_host_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state only; dp_done never reaches dp_start.
    assign o_dp_start = (r_state == S_RUN);
    assign o_busy     = (r_state == S_RUN) || (r_state == S_GAP);
    assign o_host_ack = (r_state == S_FINISH) || (r_state == S_FAULT);
    assign o_timeout  = r_timeout;

endmodule
